hazard_ctrl_scoreboard: RTL

- Parametrised successor to the pipeline hazard unit. Performs N-stage operand forwarding, store-data forwarding and multi-cycle load-use detection, used-operand aware.
- Adds sequential control: a data-memory freeze state, a multi-cycle branch-redirect flush with deferral across freezes, and saturating stall/flush performance counters.
- Sits beside the ID/EX/MEM/WB latches; drives forward muxes in EX and stall/flush/bubble enables of the latches and PC.

---
 rtl/hazard_ctrl_scoreboard.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_scoreboard.sv
// Pipeline hazard controller: N-stage operand/store forwarding, load-use stalls,
// memory freeze and multi-cycle branch flush sequencing with saturating event counters.
module hazard_ctrl_scoreboard #(
  parameter  int REG_W        = 5,
  parameter  int FWD_STAGES   = 2,
  parameter  int LOAD_READY   = 2,
  parameter  int FLUSH_CYCLES = 1,
  parameter  int CNT_W        = 16,
  localparam int SEL_W        = $clog2(FWD_STAGES + 1)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [REG_W-1:0]            rs_id,
  input  logic [REG_W-1:0]            rt_id,
  input  logic                        rs_used_id,
  input  logic                        rt_used_id,
  input  logic                        ex_regwrite,
  input  logic                        ex_is_load,
  input  logic [REG_W-1:0]            ex_wsel,
  input  logic [REG_W-1:0]            rs_ex,
  input  logic [REG_W-1:0]            rt_ex,
  input  logic                        ex_is_store,
  input  logic [FWD_STAGES-1:0]       regwrite_q,
  input  logic [FWD_STAGES-1:0]       is_load_q,
  input  logic [FWD_STAGES*REG_W-1:0] wsel_q,
  input  logic                        branch_taken,
  input  logic                        dmem_wait,
  output logic [SEL_W-1:0]            fwd_a,
  output logic [SEL_W-1:0]            fwd_b,
  output logic [SEL_W-1:0]            fwd_store,
  output logic                        stall_front,
  output logic                        bubble_ex,
  output logic                        flush_front,
  output logic                        freeze_all,
  output logic [CNT_W-1:0]            stall_cnt,
  output logic [CNT_W-1:0]            flush_cnt
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_FREEZE, ST_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic            pend_q, pend_d;
  logic            resume_q, resume_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic            load_hit;

  // Scan farthest to nearest so the nearest matching stage is the one that sticks;
  // a nearest match still waiting on load data blocks any older copy.
  function automatic logic [SEL_W-1:0] fwd_pick(
    input logic [REG_W-1:0]            src,
    input logic [FWD_STAGES-1:0]       we,
    input logic [FWD_STAGES-1:0]       ld,
    input logic [FWD_STAGES*REG_W-1:0] ws
  );
    logic [SEL_W-1:0] sel;
    logic [REG_W-1:0] dst;
    sel = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      dst = ws[(k-1)*REG_W +: REG_W];
      if (we[k-1] && (dst != '0) && (dst == src))
        sel = ((k < LOAD_READY) && ld[k-1]) ? '0 : SEL_W'(k);
    end
    return sel;
  endfunction

  function automatic logic id_reads(input logic [REG_W-1:0] dst);
    return (dst != '0) &&
           ((rs_used_id && (dst == rs_id)) || (rt_used_id && (dst == rt_id)));
  endfunction

  assign fwd_a     = fwd_pick(rs_ex, regwrite_q, is_load_q, wsel_q);
  assign fwd_b     = fwd_pick(rt_ex, regwrite_q, is_load_q, wsel_q);
  assign fwd_store = ex_is_store ? fwd_b : '0;

  always_comb begin
    load_hit = 1'b0;
    if (ex_is_load && ex_regwrite && id_reads(ex_wsel))
      load_hit = 1'b1;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      if ((k < LOAD_READY) && is_load_q[k-1] && regwrite_q[k-1] &&
          id_reads(wsel_q[(k-1)*REG_W +: REG_W]))
        load_hit = 1'b1;
    end
  end

  // Freeze outranks flush, which outranks the load-use stall; stall is masked while in reset.
  assign stall_front = nRST && (state_q == ST_RUN) && !dmem_wait && !branch_taken && load_hit;
  assign bubble_ex   = stall_front || (state_q == ST_FLUSH);
  assign flush_front = (state_q == ST_FLUSH);
  assign freeze_all  = (state_q == ST_FREEZE);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    pend_d   = pend_q;
    resume_d = resume_q;
    case (state_q)
      ST_RUN: begin
        if (dmem_wait) begin
          state_d  = ST_FREEZE;
          pend_d   = pend_q || branch_taken;
          resume_d = 1'b0;
        end else if (branch_taken) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_RELOAD;
        end
      end
      ST_FREEZE: begin
        if (dmem_wait) begin
          pend_d = pend_q || branch_taken;
        end else if (pend_q || branch_taken) begin
          state_d  = ST_FLUSH;
          fcnt_d   = FLUSH_RELOAD;
          pend_d   = 1'b0;
          resume_d = 1'b0;
        end else if (resume_q) begin
          state_d  = ST_FLUSH;
          resume_d = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // A freeze parks the flush with its remaining count intact.
        if (dmem_wait) begin
          state_d  = ST_FREEZE;
          resume_d = 1'b1;
          pend_d   = pend_q || branch_taken;
        end else if (branch_taken) begin
          fcnt_d = FLUSH_RELOAD;
        end else if (fcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_front && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if ((state_d == ST_FLUSH) && (state_q != ST_FLUSH) && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      pend_q      <= 1'b0;
      resume_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      pend_q      <= pend_d;
      resume_q    <= resume_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
